// File: rtl/ts_pkg.sv
// ts_pkg: shared constants for the Mic4 temperature sensor blocks
package ts_pkg;
  localparam int TS_COUNT_W = 32;
  localparam int TS_TIMEOUT = 1000000;
  typedef enum logic [4:0] {
    IDLE       = 5'b00001,
    TRIG       = 5'b00010,
    WAIT_VALID = 5'b00100,
    GAP        = 5'b01000,
    FINISH     = 5'b10000
  } state_e;
endpackage

// File: rtl/ts_stats_accum.sv
// ts_stats_accum: running sum, extremes and sample count for one burst
module ts_stats_accum #(
  parameter int W = 32,
  parameter int L = 3
) (
  input  logic         clk_100MHz,
  input  logic         RESET,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] avg,
  output logic [W-1:0] min_acc,
  output logic [W-1:0] max_acc,
  output logic         full
);
  logic [W+L-1:0] sum_q, sum_d;
  logic [W-1:0] min_q, min_d, max_q, max_d;
  logic [L:0] n_q, n_d;
  always_comb begin
    sum_d = clr ? '0 : load ? sum_q + {{L{1'b0}}, din} : sum_q;
    min_d = clr ? '1 : (load && din < min_q) ? din : min_q;
    max_d = clr ? '0 : (load && din > max_q) ? din : max_q;
    n_d   = clr ? '0 : load ? n_q + 1'b1 : n_q;
  end
  always_ff @(posedge clk_100MHz or posedge RESET) begin
    if (RESET) begin
      sum_q <= '0;
      min_q <= '1;
      max_q <= '0;
      n_q   <= '0;
    end else begin
      sum_q <= sum_d;
      min_q <= min_d;
      max_q <= max_d;
      n_q   <= n_d;
    end
  end
  assign avg     = sum_q[W+L-1:L];
  assign min_acc = min_q;
  assign max_acc = max_q;
  // full means the next load completes the burst
  assign full    = n_q == {1'b0, {L{1'b1}}};
endmodule

// File: rtl/ts_sample_scheduler.sv
// ts_sample_scheduler: triggers the sensor stage and reduces a burst of samples
// to mean/min/max, with a no-answer timeout.
module ts_sample_scheduler
  import ts_pkg::*;
#(
  parameter int TS_COUNT_WIDTH = TS_COUNT_W,
  parameter int AVG_LOG2       = 3,
  parameter int INTERVAL_WIDTH = 16,
  parameter int TIMEOUT        = TS_TIMEOUT
) (
  input  logic                      clk_100MHz,
  input  logic                      RESET,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [INTERVAL_WIDTH-1:0] interval,
  output logic                      pulse_in,
  input  logic [TS_COUNT_WIDTH-1:0] pulse_length,
  input  logic                      valid,
  output logic [TS_COUNT_WIDTH-1:0] avg_out,
  output logic [TS_COUNT_WIDTH-1:0] min_out,
  output logic [TS_COUNT_WIDTH-1:0] max_out,
  output logic                      done,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int TW = $clog2(TIMEOUT);
  state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [INTERVAL_WIDTH-1:0] gap_q, gap_d, ival_q, ival_d;
  logic aborted_q, aborted_d, done_q, done_d, terr_q, terr_d;
  logic [TS_COUNT_WIDTH-1:0] avg_q, avg_d, min_q, min_d, max_q, max_d;
  logic [TS_COUNT_WIDTH-1:0] acc_avg, acc_min, acc_max;
  logic clr, load, full, tmo_hit, gap_exit;
  ts_stats_accum #(.W(TS_COUNT_WIDTH), .L(AVG_LOG2)) u_acc (
    .clk_100MHz(clk_100MHz),
    .RESET     (RESET),
    .clr       (clr),
    .load      (load),
    .din       (pulse_length),
    .avg       (acc_avg),
    .min_acc   (acc_min),
    .max_acc   (acc_max),
    .full      (full)
  );
  // Both exits compare the value the counter is about to take, so GAP lasts
  // max(interval,1) cycles and the timeout fires TIMEOUT+1 cycles after trigger.
  assign tmo_hit  = 32'(tmo_q) + 1 >= TIMEOUT - 1;
  assign gap_exit = {1'b0, gap_q} + 1'b1 >= {1'b0, ival_q};
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    ival_d    = ival_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;
    terr_d    = terr_q;
    avg_d     = avg_q;
    min_d     = min_q;
    max_d     = max_q;
    clr       = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d   = TRIG;
        clr       = 1'b1;
        terr_d    = 1'b0;
        aborted_d = 1'b0;
      end
      TRIG: begin
        state_d = WAIT_VALID;
        tmo_d   = '0;
      end
      WAIT_VALID: if (valid) begin
        load    = 1'b1;
        state_d = full ? FINISH : GAP;
        gap_d   = '0;
        ival_d  = interval;
      end else begin
        tmo_d = &tmo_q ? tmo_q : tmo_q + 1'b1;
        if (tmo_hit) begin
          aborted_d = 1'b1;
          state_d   = FINISH;
        end
      end
      GAP: begin
        gap_d   = gap_q + 1'b1;
        state_d = gap_exit ? TRIG : GAP;
      end
      FINISH: begin
        done_d  = 1'b1;
        terr_d  = terr_q | aborted_q;
        avg_d   = aborted_q ? avg_q : acc_avg;
        min_d   = aborted_q ? min_q : acc_min;
        max_d   = aborted_q ? max_q : acc_max;
        clr     = continuous && !aborted_q;
        state_d = (continuous && !aborted_q) ? TRIG : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_100MHz or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      gap_q     <= '0;
      ival_q    <= '0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
      avg_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      ival_q    <= ival_d;
      aborted_q <= aborted_d;
      done_q    <= done_d;
      terr_q    <= terr_d;
      avg_q     <= avg_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end
  assign pulse_in    = state_q[1];
  assign busy        = !state_q[0];
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign avg_out     = avg_q;
  assign min_out     = min_q;
  assign max_out     = max_q;
endmodule

// File: doc/ts_sample_scheduler.md
# ts_sample_scheduler

Measurement scheduler and averager for the Mic4 temperature sensor. It sits directly upstream and downstream of the sensor pulse-timing stage. It issues the trigger pulse to that stage, captures each returned `pulse_length` on its one-cycle `valid` strobe, and reduces a burst of 2^AVG_LOG2 samples to average, minimum and maximum values for the control register file. A timeout guards against a chip that never answers.

## Interface
- `TS_COUNT_WIDTH`, 32, width of sensor pulse-length samples
- `AVG_LOG2`, 3, log2 of samples per burst (1..8)
- `INTERVAL_WIDTH`, 16, width of the inter-sample gap setting
- `TIMEOUT`, 1000000, cycles allowed from trigger to `valid` (10 ms)

Ports:
- `clk_100MHz`  in  1  control clock
- `RESET`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a burst; sampled only in IDLE
- `continuous`  in  1  start a new burst automatically after each completed burst
- `interval`  in  INTERVAL_WIDTH  idle cycles between samples (0 gives 1 cycle)
- `pulse_in`  out  1  one-cycle trigger to the sensor stage
- `pulse_length`  in  TS_COUNT_WIDTH  sample from the sensor stage; only meaningful while `valid`=1
- `valid`  in  1  one-cycle sample strobe from the sensor stage
- `avg_out`  out  TS_COUNT_WIDTH  truncated mean of the last successful burst
- `min_out` / `max_out`  out  TS_COUNT_WIDTH  extremes of the last successful burst
- `done`  out  1  one-cycle end-of-burst strobe
- `busy`  out  1  high in every state except IDLE
- `timeout_err`  out  1  sticky; cleared when the next burst is accepted

## Operation
- One-hot FSM with states IDLE, TRIG, WAIT_VALID, GAP, FINISH.
- **IDLE**
  - On `start`=1: go to TRIG.
  - On the same edge: clear `sum`, `n` and `timeout_err`; set `min_acc` to all ones and `max_acc` to 0.
- **TRIG**
  - Lasts exactly 1 cycle.
  - `pulse_in` = 1 during this cycle, decoded from the registered state bit.
  - Next state is WAIT_VALID; the timeout counter is cleared.
- **WAIT_VALID**
  - On `valid`=1:
    - `sum` += `pulse_length`
    - `min_acc` = min(`min_acc`, `pulse_length`); `max_acc` = max(`max_acc`, `pulse_length`)
    - `n` += 1
    - Go to FINISH if the new `n` equals 2^AVG_LOG2, otherwise go to GAP.
  - Without `valid`: the timeout counter increments. When it reaches TIMEOUT-1, set `timeout_err`=1 and go to FINISH with the burst aborted.
  - If `valid` and the timeout coincide in the same cycle, `valid` wins.
- **GAP**
  - Counter runs from 0; exit to TRIG when the count is >= `interval`.
  - This guarantees the sensor stage is back in its idle state before the next trigger.
- **FINISH**
  - Lasts 1 cycle. On exit, register `done`=1 for one cycle.
  - Successful burst: `avg_out` = `sum` >> AVG_LOG2, `min_out` = `min_acc`, `max_out` = `max_acc`.
  - Aborted burst: `avg_out`, `min_out` and `max_out` hold their previous values.
  - Next state is TRIG if `continuous`=1 and the burst succeeded (with `sum`/`n`/`min_acc`/`max_acc` re-initialised), otherwise IDLE.
  - After a timeout the block always returns to IDLE.
- Width rules:
  - `sum` is TS_COUNT_WIDTH+AVG_LOG2 bits and never overflows.
  - `n` is AVG_LOG2+1 bits.
  - The timeout counter is clog2(TIMEOUT) bits and saturates.
- Ignored inputs:
  - `valid` outside WAIT_VALID.
  - `start` outside IDLE.
  - A change in `continuous` mid-burst takes effect at FINISH.
  - `interval` is sampled on entry to GAP.

## Timing
- Reset values: `pulse_in`, `done`, `busy` and `timeout_err` are 0; `avg_out`, `min_out` and `max_out` are all zeros; the FSM is in IDLE.
- `RESET` asserted mid-burst forces all of the above immediately (asynchronously). The sensor stage shares `RESET`.
- Start to trigger: `start` high in cycle c puts `pulse_in` high in cycle c+1.
- Sample to sample: a final-sample `valid` in cycle t puts FINISH in t+1, `done` and the updated outputs in t+2.
- Non-final sample: `valid` in cycle t puts GAP in t+1..t+max(`interval`,1), then the next `pulse_in` in the following cycle.
- Continuous mode: the next burst's `pulse_in` is high in the same cycle as `done`.
- Timeout: `timeout_err` rises in the same cycle as `done`, TIMEOUT+1 cycles after `pulse_in`.

## Structure
- Shared package `ts_pkg` holds:
  - the one-hot state encoding constants for IDLE, TRIG, WAIT_VALID, GAP and FINISH;
  - the default TS_COUNT_WIDTH;
  - the TIMEOUT constant.
  The sensor stage reuses TS_COUNT_WIDTH from the same package.
- One sub-module, `ts_stats_accum`, holds the `sum`, `min_acc`, `max_acc` and `n` registers. Its controls are clear, load (on `valid`) and a full flag.
- The FSM, gap counter and timeout counter live in the top module.

## Test plan
- **Basic burst:** AVG_LOG2=2, `interval`=5, one `start`; the sensor model returns 100, 200, 300, 400 -> four `pulse_in` strobes, each GAP lasting 5 cycles; a single `done`; `avg_out`=250, `min_out`=100, `max_out`=400.
- **Truncation:** samples 1, 2, 2, 2 -> `avg_out`=1, `min_out`=1, `max_out`=2.
- **Timeout:** TIMEOUT=1000, the model never answers after a prior 250 result -> `timeout_err`=1 and `done`=1 exactly 1001 cycles after `pulse_in`; `avg_out` stays 250; the FSM returns to IDLE.
- **Continuous mode:** `continuous`=1 -> `pulse_in` high in the `done` cycle. Drop `continuous` mid-burst -> that burst completes, then `busy`=0.
- **Reset mid-burst:** `RESET` pulsed in WAIT_VALID -> all outputs 0 at once. A `valid` arriving after release is ignored; `busy` stays 0.
- **Ignored inputs:** `start` pulses in GAP and a stray `valid` in IDLE or GAP -> no extra trigger; `sum`/`n` unchanged.
